uart_prog_loader: RTL and testbench

Receives a program image over a serial UART line and writes it word-by-word into the RV32I core's instruction/data RAM. It holds the core halted while loading. It sits between the top-level `ui_in` RX pin and the core's memory write port. It releases the core only after a complete, well-formed image has been received.

---
 rtl/uart_loader_pkg.sv | 16 +
 rtl/uart_rx_byte.sv | 70 +++++++
 rtl/uart_prog_loader.sv | 159 +++++++++++++++
 tb/tb_uart_prog_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART program loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CHECK
    } load_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
    localparam int         CLKS_PER_BIT_DEF = 104;
    localparam int         CNT_W            = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling timer, LSB-first shifter.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);
    localparam int             CW      = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_sync, rx_prev;
    logic          active, done_q, stop_q, sample;
    logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;

    assign sample = active && (cnt == ((bit_idx == 4'd0) ? HALF_M1 : FULL_M1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            active  <= 1'b0;
            done_q  <= 1'b0;
            stop_q  <= 1'b1;
            bit_idx <= '0;
            cnt     <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            done_q  <= 1'b0;
            if (!active) begin
                if (rx_prev && !rx_sync) begin
                    active  <= 1'b1;
                    bit_idx <= '0;
                    cnt     <= '0;
                end
            end else if (!sample) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                if (bit_idx == 4'd0) begin
                    // Start bit high at mid-point: treat the edge as a glitch.
                    if (rx_sync) active <= 1'b0;
                    else         bit_idx <= 4'd1;
                end else if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    done_q <= 1'b1;
                    stop_q <= rx_sync;
                end else begin
                    shreg   <= {rx_sync, shreg[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

    assign byte_o      = shreg;
    assign valid_o     = done_q & stop_q;
    assign frame_err_o = done_q & ~stop_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: parses SYNC/count/data frames and writes words into core RAM while halting it.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_halt_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic              busy_o
);
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif
    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(1) << ADDR_W;

    logic [7:0]        rx_byte;
    logic              rx_valid, rx_ferr;
    load_state_e       state_q, state_d;
    logic [7:0]        cnt_lo_q, csum_q;
    logic [CNT_W-1:0]  n_words, words_left;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        byte_idx;
    logic [31:0]       word_q;
    logic              last_q, too_many, last_word;
    logic              sync_fire, write_fire, err_fire, done_fire;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    assign n_words   = {rx_byte, cnt_lo_q};
    assign too_many  = {1'b0, n_words} > MAX_WORDS;
    assign last_word = (words_left == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (sync_fire) state_d = ST_CNT_LO;
            ST_CNT_LO: if (rx_valid)  state_d = ST_CNT_HI;
            ST_CNT_HI: if (rx_valid) begin
                if (too_many)            state_d = ST_IDLE;
                else if (n_words == '0)  state_d = CS_EN ? ST_CHECK : ST_IDLE;
                else                     state_d = ST_DATA;
            end
            ST_DATA:   if (write_fire && last_word) state_d = CS_EN ? ST_CHECK : ST_IDLE;
            ST_CHECK:  if (rx_valid) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && rx_ferr) state_d = ST_IDLE;
    end

    always_comb begin
        sync_fire  = 1'b0;
        write_fire = 1'b0;
        err_fire   = 1'b0;
        // Without a checksum, done trails the final write strobe by one cycle.
        done_fire  = last_q && !CS_EN;
        case (state_q)
            ST_IDLE:   sync_fire = rx_valid && (rx_byte == SYNC_BYTE);
            ST_CNT_HI: if (rx_valid) begin
                if (too_many)           err_fire  = 1'b1;
                else if (n_words == '0) done_fire = !CS_EN;
            end
            ST_DATA:   write_fire = rx_valid && (byte_idx == 2'd3);
            ST_CHECK:  if (rx_valid) begin
                if (rx_byte == csum_q) done_fire = 1'b1;
                else                   err_fire  = 1'b1;
            end
            default: ;
        endcase
        if (busy_o && rx_ferr) err_fire = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            cpu_halt_o  <= 1'b1;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
            busy_o      <= 1'b0;
            cnt_lo_q    <= '0;
            csum_q      <= '0;
            words_left  <= '0;
            addr_q      <= '0;
            byte_idx    <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            mem_we_o    <= write_fire;
            load_done_o <= done_fire;
            last_q      <= write_fire && last_word;
            if (sync_fire) begin
                busy_o     <= 1'b1;
                cpu_halt_o <= 1'b1;
                load_err_o <= 1'b0;
                addr_q     <= '0;
                byte_idx   <= '0;
                csum_q     <= '0;
            end
            if (err_fire) begin
                load_err_o <= 1'b1;
                busy_o     <= 1'b0;
            end
            if (done_fire) begin
                busy_o     <= 1'b0;
                cpu_halt_o <= 1'b0;
            end
            if (rx_valid) begin
                case (state_q)
                    ST_CNT_LO: begin
                        cnt_lo_q <= rx_byte;
                        csum_q   <= csum_q ^ rx_byte;
                    end
                    ST_CNT_HI: begin
                        words_left <= n_words;
                        csum_q     <= csum_q ^ rx_byte;
                    end
                    ST_DATA: begin
                        csum_q   <= csum_q ^ rx_byte;
                        word_q   <= {rx_byte, word_q[31:8]};
                        byte_idx <= byte_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (write_fire) begin
                mem_addr_o  <= addr_q;
                mem_wdata_o <= {rx_byte, word_q[31:8]};
                addr_q      <= addr_q + 1'b1;
                words_left  <= words_left - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader at 16 clocks per UART bit.
module tb_uart_prog_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        mem_we, cpu_halt, load_done, load_err, busy;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_total = 0, done_total = 0, halt_bad = 0;
    logic [7:0]  frame [$];

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx_i(rx),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .cpu_halt_o(cpu_halt), .load_done_o(load_done), .load_err_o(load_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[wr_total % 64] = mem_addr;
            wr_data[wr_total % 64] = mem_wdata;
            wr_total++;
        end
        if (load_done) begin
            done_total++;
            if (cpu_halt) halt_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (2 * CPB) @(negedge clk);
    endtask

    // Appends the XOR of every byte after index sync_idx when the checksum build is selected.
    task automatic add_csum(input int sync_idx);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = sync_idx + 1; i < frame.size(); i++) x ^= frame[i];
        frame.push_back(x);
`else
        if (sync_idx < 0) frame.delete();
`endif
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (cpu_halt !== 1'b1) begin errors++; $display("FAIL reset_halt: got %b want 1", cpu_halt); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", load_done); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", load_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_addr_data: got %h/%h want 00/00000000", mem_addr, mem_wdata); end
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        checks++; if (wr_total !== 0 || done_total !== 0) begin
            errors++; $display("FAIL idle_strobes: got we=%0d done=%0d want 0/0", wr_total, done_total); end
        checks++; if (cpu_halt !== 1'b1) begin errors++; $display("FAIL idle_halt: got %b want 1", cpu_halt); end
    endtask

    task automatic test_basic_load();
        int wb = wr_total, db = done_total;
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        add_csum(0);
        send_frame();
        checks++; if (wr_total - wb !== 2) begin errors++; $display("FAIL basic_nwr: got %0d want 2", wr_total - wb); end
        checks++; if (wr_addr[wb % 64] !== 8'h00 || wr_data[wb % 64] !== 32'h00000013) begin
            errors++; $display("FAIL basic_w0: got %h@%h want 00000013@00", wr_data[wb % 64], wr_addr[wb % 64]); end
        checks++; if (wr_addr[(wb + 1) % 64] !== 8'h01 || wr_data[(wb + 1) % 64] !== 32'h00100093) begin
            errors++; $display("FAIL basic_w1: got %h@%h want 00100093@01", wr_data[(wb + 1) % 64], wr_addr[(wb + 1) % 64]); end
        checks++; if (done_total - db !== 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_total - db); end
        checks++; if (cpu_halt !== 1'b0 || busy !== 1'b0 || load_err !== 1'b0) begin
            errors++; $display("FAIL basic_status: got halt=%b busy=%b err=%b want 0/0/0", cpu_halt, busy, load_err); end
        checks++; if (halt_bad !== 0) begin errors++; $display("FAIL basic_halt_at_done: got %0d want 0", halt_bad); end
    endtask

    task automatic test_leading_bytes();
        int wb = wr_total, db = done_total;
        frame = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        add_csum(2);
        send_frame();
        checks++; if (wr_total - wb !== 1) begin errors++; $display("FAIL lead_nwr: got %0d want 1", wr_total - wb); end
        checks++; if (wr_addr[wb % 64] !== 8'h00 || wr_data[wb % 64] !== 32'hEFBEADDE) begin
            errors++; $display("FAIL lead_w0: got %h@%h want efbeadde@00", wr_data[wb % 64], wr_addr[wb % 64]); end
        checks++; if (done_total - db !== 1 || cpu_halt !== 1'b0) begin
            errors++; $display("FAIL lead_done: got done=%0d halt=%b want 1/0", done_total - db, cpu_halt); end
    endtask

    task automatic test_count_overflow();
        int wb = wr_total, db = done_total;
        frame = '{8'hA5, 8'h01, 8'h01};
        send_frame();
        checks++; if (load_err !== 1'b1 || cpu_halt !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_status: got err=%b halt=%b busy=%b want 1/1/0", load_err, cpu_halt, busy); end
        checks++; if (wr_total - wb !== 0 || done_total - db !== 0) begin
            errors++; $display("FAIL ovf_strobes: got we=%0d done=%0d want 0/0", wr_total - wb, done_total - db); end
        wb = wr_total;
        frame = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        add_csum(0);
        send_frame();
        checks++; if (load_err !== 1'b0 || cpu_halt !== 1'b0) begin
            errors++; $display("FAIL ovf_recover: got err=%b halt=%b want 0/0", load_err, cpu_halt); end
        checks++; if (wr_total - wb !== 1 || wr_data[wb % 64] !== 32'h12345678 || wr_addr[wb % 64] !== 8'h00) begin
            errors++; $display("FAIL ovf_recover_wr: got n=%0d %h@%h want 1 12345678@00", wr_total - wb, wr_data[wb % 64], wr_addr[wb % 64]); end
    endtask

    task automatic test_frame_error();
        int wb = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        frame = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame();
        checks++; if (load_err !== 1'b1 || cpu_halt !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ferr_status: got err=%b halt=%b busy=%b want 1/1/0", load_err, cpu_halt, busy); end
        checks++; if (wr_total - wb !== 0) begin errors++; $display("FAIL ferr_nwr: got %0d want 0", wr_total - wb); end
    endtask

    task automatic test_zero_count();
        int wb = wr_total, db = done_total;
        frame = '{8'hA5, 8'h00, 8'h00};
        add_csum(0);
        send_frame();
        checks++; if (done_total - db !== 1 || wr_total - wb !== 0 || cpu_halt !== 1'b0) begin
            errors++; $display("FAIL zero_cnt: got done=%0d we=%0d halt=%b want 1/0/0", done_total - db, wr_total - wb, cpu_halt); end
    endtask

    task automatic test_reset_mid_frame();
        int wb = wr_total;
        frame = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame();
        checks++; if (wr_total - wb !== 2 || mem_addr !== 8'h01 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got n=%0d addr=%h busy=%b want 2/01/1", wr_total - wb, mem_addr, busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || cpu_halt !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset: got we=%b busy=%b halt=%b addr=%h data=%h want 0/0/1/00/0",
                               mem_we, busy, cpu_halt, mem_addr, mem_wdata); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        wb = wr_total;
        frame = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        add_csum(0);
        send_frame();
        checks++; if (wr_total - wb !== 1 || wr_addr[wb % 64] !== 8'h00 || wr_data[wb % 64] !== 32'hDDCCBBAA) begin
            errors++; $display("FAIL mid_reload: got n=%0d %h@%h want 1 ddccbbaa@00", wr_total - wb, wr_data[wb % 64], wr_addr[wb % 64]); end
        checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL mid_reload_halt: got %b want 0", cpu_halt); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int db = done_total;
        frame = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        send_frame();
        checks++; if (load_err !== 1'b1 || cpu_halt !== 1'b1 || done_total - db !== 0) begin
            errors++; $display("FAIL bad_csum: got err=%b halt=%b done=%0d want 1/1/0", load_err, cpu_halt, done_total - db); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_leading_bytes();
        test_count_overflow();
        test_frame_error();
        test_zero_count();
        test_reset_mid_frame();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
